alu_cmd_issue: RTL

- Upstream issue stage for the team's combinational 4-bit ALU (3-bit opcode s, 4-bit a/b, 8-bit out).
- Accepts opcode/operand commands over a valid/ready handshake and buffers them in a small FIFO.
- Presents the FIFO head to the ALU, then captures the ALU result into a registered, back-pressurable output with an error flag.

---
 rtl/alu_cmd_issue_if.sv | 40 ++++
 rtl/alu_cmd_issue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue_if.sv
// ============================================================================
// Module  : alu_cmd_issue_if
// Purpose : Command, ALU-drive and result signals of the ALU issue stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_cmd_issue_if #(
   parameter int PTR_W = 2
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic [2:0]       alu_s;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [7:0]       alu_out;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_data;
   logic [2:0]       res_op;
   logic             res_err;
   logic [PTR_W:0]   count;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
      output cmd_ready, alu_s, alu_a, alu_b, res_valid, res_data, res_op,
             res_err, count
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
      input  cmd_ready, alu_s, alu_a, alu_b, res_valid, res_data, res_op,
             res_err, count
   );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_issue.sv
// ============================================================================
// Module  : alu_cmd_issue
// Purpose : FIFO-buffered command issue to a combinational ALU with a
//           registered, back-pressurable result slot and div-by-zero flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cmd_issue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_cmd_issue_if.slave  bus
);
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } out_state_t;

   localparam int             ENTRY_W  = 11;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   out_state_t         state_q, state_d;
   logic [7:0]         res_data_q, res_data_d;
   logic [2:0]         res_op_q, res_op_d;
   logic               res_err_q, res_err_d;

   logic [ENTRY_W-1:0] head;
   logic [2:0]         head_op;
   logic [3:0]         head_a;
   logic [3:0]         head_b;
   logic               empty;
   logic               full;
   logic               out_free;
   logic               push;
   logic               pop;
   logic               div_zero;

   assign head     = mem_q[rd_ptr_q];
   assign head_op  = head[10:8];
   assign head_a   = head[7:4];
   assign head_b   = head[3:0];
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign out_free = (state_q == ST_IDLE) || bus.res_ready;
   assign push     = bus.cmd_valid && !full;
   assign pop      = !empty && out_free;
   assign div_zero = (head_op == 3'b011) && (head_b == 4'd0);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      state_d    = state_q;
      res_data_d = res_data_q;
      res_op_d   = res_op_q;
      res_err_d  = res_err_q;

      if (push) begin
         mem_d[wr_ptr_q] = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A pop always refills the slot, so HOLD persists across back-to-back results.
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         state_d    = ST_HOLD;
         res_op_d   = head_op;
         res_err_d  = div_zero;
         res_data_d = div_zero ? 8'hFF : bus.alu_out;
      end else if (state_q == ST_HOLD && bus.res_ready) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         res_data_q <= '0;
         res_op_q   <= '0;
         res_err_q  <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         res_data_q <= res_data_d;
         res_op_q   <= res_op_d;
         res_err_q  <= res_err_d;
      end
   end

   assign bus.cmd_ready = !full;
   assign bus.alu_s     = empty ? 3'd0 : head_op;
   assign bus.alu_a     = empty ? 4'd0 : head_a;
   assign bus.alu_b     = empty ? 4'd0 : head_b;
   assign bus.res_valid = (state_q == ST_HOLD);
   assign bus.res_data  = res_data_q;
   assign bus.res_op    = res_op_q;
   assign bus.res_err   = res_err_q;
   assign bus.count     = count_q;

endmodule

`default_nettype wire
